// File: rtl/pio_pkg.sv
// Shared constants for the PIO input block: register word addresses and edge modes.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the PIO input block (register access + irq).
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
endinterface

// File: rtl/pio_in_conditioner.sv
// Pin conditioning: 2-flop synchroniser per bit, optionally followed by a
// per-bit debounce filter when PIO_DEBOUNCE_EN is defined.
module pio_in_conditioner #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_cond_in
);

  logic [WIDTH-1:0] r_s1, r_s2;

  // Two-stage metastability chain on the raw pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0]         r_filt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    // Count consecutive cycles where the synced pin disagrees with the
    // filtered value; adopt the new level on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt[i]  <= '0;
        r_filt[i] <= 1'b0;
      end else if (r_s2[i] == r_filt[i]) begin
        r_cnt[i]  <= '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        r_cnt[i]  <= '0;
        r_filt[i] <= r_s2[i];
      end else begin
        r_cnt[i]  <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign o_cond_in = r_filt;
`else
  assign o_cond_in = r_s2;
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// PIO input port with edge capture and masked level IRQ on an Avalon-MM slave.
// Optional debounce of the pins is enabled with the PIO_DEBOUNCE_EN macro.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH           = 10,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] IRQ_RESET_MASK  = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_port,
  pio_in_edge_irq_if.slave   bus
);

  logic [WIDTH-1:0] w_cond, w_rise, w_fall, w_edge;
  logic [WIDTH-1:0] w_clr, w_ecap_nxt, w_mask_nxt;
  logic             w_wr;
  logic [31:0]      w_rd_mux;

  logic [WIDTH-1:0] r_prev, r_mask, r_ecap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  pio_in_conditioner #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_cond (
    .clk       (clk),
    .rst       (reset),
    .i_in      (in_port),
    .o_cond_in (w_cond)
  );

  assign w_wr   = bus.chipselect & ~bus.write_n;
  assign w_rise = w_cond & ~r_prev;
  assign w_fall = ~w_cond & r_prev;

  // Edge selection and next-state of the mask/capture registers
  always_comb begin
    w_edge     = w_rise;
    w_clr      = '0;
    w_mask_nxt = r_mask;
    case (edge_mode_e'(EDGE_TYPE))
      EDGE_FALL: w_edge = w_fall;
      EDGE_ANY:  w_edge = w_rise | w_fall;
      default:   w_edge = w_rise;
    endcase
    if (w_wr && bus.address == ADDR_EDGECAP) w_clr      = bus.writedata[WIDTH-1:0];
    if (w_wr && bus.address == ADDR_IRQMASK) w_mask_nxt = bus.writedata[WIDTH-1:0];
    // A fresh edge beats a same-cycle clear
    w_ecap_nxt = (r_ecap & ~w_clr) | w_edge;
  end

  // Read mux; shows register state from before any same-cycle write
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    w_rd_mux = 32'(w_cond);
      ADDR_IRQMASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGECAP: w_rd_mux = 32'(r_ecap);
      default:      w_rd_mux = '0;
    endcase
  end

  // Register file, edge history, read data and irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev     <= '0;
      r_mask     <= IRQ_RESET_MASK[WIDTH-1:0];
      r_ecap     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_cond;
      r_mask     <= w_mask_nxt;
      r_ecap     <= w_ecap_nxt;
      r_readdata <= w_rd_mux;
      r_irq      <= |(w_ecap_nxt & w_mask_nxt);
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq (WIDTH=10, rising capture).
// Build with PIO_DEBOUNCE_EN to also exercise the debounce filter (8 cycles).
module tb_pio_in_edge_irq;

`ifdef PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int SL = 2 + DB;   // pin change -> conditioned value valid
  localparam logic [31:0] RMASK = 32'h155;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_port;

  pio_in_edge_irq_if bus_if ();

  pio_in_edge_irq #(
    .WIDTH           (10),
    .EDGE_TYPE       (0),
    .IRQ_RESET_MASK  (RMASK),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .in_port (in_port),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] sb_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick(1);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  // Drive a read address, queue the expectation, compare when readdata lands
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus_if.address = a;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    tick(1);
    chk(tag_q.pop_front(), bus_if.readdata, sb_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    in_port = '0;
    bus_if.address = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1;
    bus_if.writedata = '0;
    tick(2);
    chk("rst_rd", bus_if.readdata, 32'h0);
    chk("rst_irq", {31'h0, bus_if.irq}, 32'h0);
    rst = 1'b0;
    rd(2'd2, RMASK, "rst_mask");
    rd(2'd3, 32'h0, "rst_ecap");
    rd(2'd1, 32'h0, "rsvd");

    // Data read, rising capture of the set bits, reset mask drives irq
    in_port = 10'h2A5;
    tick(SL + 1);
    rd(2'd0, 32'h2A5, "data");
    chk("irq_rstmask", {31'h0, bus_if.irq}, 32'h1);
    rd(2'd3, 32'h2A5, "ecap_rise");
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h2A5, "data_ro");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h3FF, "mask_width");
    wr(2'd1, 32'h0000_FFFF);
    rd(2'd1, 32'h0, "rsvd_wr");
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    chk("irq_clr_all", {31'h0, bus_if.irq}, 32'h0);
    rd(2'd3, 32'h0, "w1c_all");

    // Falling edges are ignored; exact rising-edge latency on bit0
    in_port = 10'h0;
    tick(SL + 2);
    rd(2'd3, 32'h0, "fall_none");
    wr(2'd2, 32'h1);
    bus_if.address = 2'd3;
    in_port = 10'h001;
    tick(SL);
    chk("irq_early", {31'h0, bus_if.irq}, 32'h0);
    tick(1);
    chk("irq_edge", {31'h0, bus_if.irq}, 32'h1);
    rd(2'd3, 32'h1, "ecap_b0");
    in_port = 10'h000;
    tick(SL + 2);
    rd(2'd3, 32'h1, "fall_hold");

    // W1C per bit, and an edge colliding with a clear
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h3);
    in_port = 10'h003;
    tick(SL + 2);
    rd(2'd3, 32'h3, "ecap_3");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, "w1c_b0");
    chk("irq_b1", {31'h0, bus_if.irq}, 32'h1);
    in_port = 10'h001;
    tick(SL + 2);
    in_port = 10'h003;
    tick(SL);
    wr(2'd3, 32'h2);
    chk("irq_collide", {31'h0, bus_if.irq}, 32'h1);
    rd(2'd3, 32'h2, "w1c_collide");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "w1c_b1");
    chk("irq_b1_clr", {31'h0, bus_if.irq}, 32'h0);

    // Masking
    wr(2'd2, 32'h0);
    in_port = 10'h007;
    tick(SL + 2);
    chk("irq_masked", {31'h0, bus_if.irq}, 32'h0);
    rd(2'd3, 32'h4, "ecap_b2");
    wr(2'd2, 32'h4);
    chk("irq_unmask", {31'h0, bus_if.irq}, 32'h1);
    wr(2'd2, 32'h0);
    chk("irq_remask", {31'h0, bus_if.irq}, 32'h0);

    // Asynchronous reset mid-run with all pins high
    in_port = 10'h3FF;
    bus_if.address = 2'd0;
    tick(SL + 2);
    chk("pre_rst", bus_if.readdata, 32'h3FF);
    rst = 1'b1;
    #1;
    chk("arst_rd", bus_if.readdata, 32'h0);
    chk("arst_irq", {31'h0, bus_if.irq}, 32'h0);
    tick(1);
    rst = 1'b0;
    rd(2'd2, RMASK, "rst2_mask");
    rd(2'd3, 32'h0, "rst2_ecap");
    tick(DB + 1);
    chk("rst2_irq", {31'h0, bus_if.irq}, 32'h1);
    rd(2'd3, 32'h3FF, "rst2_edge");

`ifdef PIO_DEBOUNCE_EN
    // Short glitch filtered out; a held level captured after 8 stable cycles
    in_port = 10'h3FE;
    tick(SL + 2);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 10'h3FF;
    tick(5);
    in_port = 10'h3FE;
    tick(20);
    rd(2'd3, 32'h0, "db_glitch");
    in_port = 10'h3FF;
    tick(10);
    rd(2'd3, 32'h0, "db_early");
    rd(2'd3, 32'h1, "db_cap");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
